// File: rtl/iter_divider.sv
// Radix-2 restoring divider, one iteration per clock, {remainder, quotient} result.
// Optional early-out for |dividend| < |divisor| enabled by ITER_DIV_EARLY_OUT_EN.
module iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_rem, w_rem_nxt;
    logic [WIDTH-1:0]   r_quo, w_quo_nxt;
    logic [WIDTH-1:0]   r_div, w_div_nxt;
    logic               r_q_neg, w_q_neg_nxt;
    logic               r_r_neg, w_r_neg_nxt;
    logic [2*WIDTH-1:0] r_result, w_result_nxt;
    logic               r_ready, w_ready_nxt;
`ifdef ITER_DIV_EARLY_OUT_EN
    logic               r_early, w_early_nxt;
`endif

    logic               w_sign1, w_sign2;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [WIDTH:0]     w_shift, w_trial;
    logic [WIDTH-1:0]   w_quo_step, w_rem_step, w_quo_fix, w_rem_fix;

    // Operand magnitudes; the most negative value maps onto itself as unsigned.
    assign w_sign1 = signed_div_i & opdata1_i[WIDTH-1];
    assign w_sign2 = signed_div_i & opdata2_i[WIDTH-1];
    assign w_mag1  = w_sign1 ? -opdata1_i : opdata1_i;
    assign w_mag2  = w_sign2 ? -opdata2_i : opdata2_i;

    // Remainder stays below the divisor, so the WIDTH+1 trial sign bit is exact.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_quo_step = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_rem_step = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_fix  = r_q_neg ? -w_quo_step : w_quo_step;
    assign w_rem_fix  = r_r_neg ? -w_rem_step : w_rem_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
`ifdef ITER_DIV_EARLY_OUT_EN
            r_early  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_div    <= w_div_nxt;
            r_q_neg  <= w_q_neg_nxt;
            r_r_neg  <= w_r_neg_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
`ifdef ITER_DIV_EARLY_OUT_EN
            r_early  <= w_early_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_div_nxt    = r_div;
        w_q_neg_nxt  = r_q_neg;
        w_r_neg_nxt  = r_r_neg;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
`ifdef ITER_DIV_EARLY_OUT_EN
        w_early_nxt  = r_early;
`endif
        case (r_state)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    w_cnt_nxt   = '0;
                    w_rem_nxt   = '0;
                    w_quo_nxt   = w_mag1;
                    w_div_nxt   = w_mag2;
                    w_q_neg_nxt = w_sign1 ^ w_sign2;
                    w_r_neg_nxt = w_sign1;
`ifdef ITER_DIV_EARLY_OUT_EN
                    w_early_nxt = 1'b0;
                    if (opdata2_i == '0) begin
                        w_state_nxt = S_DIVZERO;
                    end else if (w_mag1 < w_mag2) begin
                        w_state_nxt = S_DIVZERO;
                        w_early_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ON;
                    end
`else
                    w_state_nxt = (opdata2_i == '0) ? S_DIVZERO : S_ON;
`endif
                end
            end
            S_DIVZERO: begin
                if (annul_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end else begin
                    w_state_nxt  = S_END;
                    w_ready_nxt  = 1'b1;
                    w_result_nxt = '0;
`ifdef ITER_DIV_EARLY_OUT_EN
                    // Early-out shares this one-cycle path; remainder is the dividend.
                    if (r_early) begin
                        w_result_nxt = {(r_r_neg ? -r_quo : r_quo), {WIDTH{1'b0}}};
                    end
`endif
                end
            end
            S_ON: begin
                if (annul_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end else begin
                    w_rem_nxt = w_rem_step;
                    w_quo_nxt = w_quo_step;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_nxt  = S_END;
                        w_ready_nxt  = 1'b1;
                        w_result_nxt = {w_rem_fix, w_quo_fix};
                    end
                end
            end
            S_END: begin
                if (!start_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_FREE;
            end
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus randomized
// operands against an arithmetic reference model.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    iter_divider #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: MIPS DIV/DIVU via 64-bit arithmetic; latency in edges after acceptance.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [63:0] res, output int lat);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            res = 64'd0;
            lat = 1;
            return;
        end
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
        lat = 32;
`ifdef ITER_DIV_EARLY_OUT_EN
        if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) lat = 1;
`endif
    endfunction

    // Full handshake; operands are scrambled right after acceptance.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [63:0] res,
                          output logic rdy2, output logic [63:0] res2,
                          output logic rdy_drop, output logic [63:0] res_drop);
        @(negedge clk);
        opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
        @(posedge clk); #1;
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin lat = k; break; end
        end
        res = result_o;
        @(posedge clk); #1;
        rdy2 = ready_o; res2 = result_o;
        start_i = 1'b0;
        @(posedge clk); #1;
        rdy_drop = ready_o; res_drop = result_o;
    endtask

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'd3};
        logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd10};
        logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [63:0] tr [7] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                                64'h0, 64'h00000000_80000000, 64'h00000000_FFFFFFFF,
                                64'h00000003_00000000};
        int          tl [7];
        int lat;
        logic [63:0] res, res2, res_drop;
        logic rdy2, rdy_drop;
        tl = '{32, 32, 32, 1, 32, 32, 32};
`ifdef ITER_DIV_EARLY_OUT_EN
        tl[6] = 1;
`endif
        for (int i = 0; i < 7; i++) begin
            do_div(ta[i], tb[i], ts[i], lat, res, rdy2, res2, rdy_drop, res_drop);
            checks++;
            if (lat !== tl[i]) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
            checks++;
            if (res !== tr[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, res, tr[i]); end
            checks++;
            if (rdy2 !== 1'b1 || res2 !== tr[i]) begin
                errors++; $display("FAIL dir%0d_hold: got rdy=%b res=%h want rdy=1 res=%h", i, rdy2, res2, tr[i]);
            end
            checks++;
            if (rdy_drop !== 1'b0 || res_drop !== 64'd0) begin
                errors++; $display("FAIL dir%0d_release: got rdy=%b res=%h want 0/0", i, rdy_drop, res_drop);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic s;
        logic [63:0] exp_res, res, res2, res_drop;
        int exp_lat, lat;
        logic rdy2, rdy_drop;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 20));
                1: b = 32'd0;
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            ref_div(a, b, s, exp_res, exp_lat);
            do_div(a, b, s, lat, res, rdy2, res2, rdy_drop, res_drop);
            checks++;
            if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency (%h/%h s=%b): got %0d want %0d", i, a, b, s, lat, exp_lat); end
            checks++;
            if (res !== exp_res) begin errors++; $display("FAIL rnd%0d_result (%h/%h s=%b): got %h want %h", i, a, b, s, res, exp_res); end
            checks++;
            if (rdy_drop !== 1'b0 || res_drop !== 64'd0) begin
                errors++; $display("FAIL rnd%0d_release: got rdy=%b res=%h want 0/0", i, rdy_drop, res_drop);
            end
        end
    endtask

    task automatic test_start_drop;
        logic early_rdy = 1'b0;
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            if (k == 3) start_i = 1'b0;
            if (ready_o) early_rdy = 1'b1;
        end
        checks++;
        if (early_rdy !== 1'b0) begin errors++; $display("FAIL drop_early_ready: got 1 want 0"); end
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
            errors++; $display("FAIL drop_result: got rdy=%b res=%h want rdy=1 res=000000020000000e", ready_o, result_o);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL drop_release: got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_annul;
        logic rose = 1'b0;
        int lat;
        logic [63:0] res, res2, res_drop;
        logic rdy2, rdy_drop;
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL annul_state: got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) rose = 1'b1;
        end
        checks++;
        if (rose !== 1'b0) begin errors++; $display("FAIL annul_no_result: got ready rise want none"); end
        do_div(32'd100, 32'd7, 1'b0, lat, res, rdy2, res2, rdy_drop, res_drop);
        checks++;
        if (lat !== 32 || res !== 64'h00000002_0000000E) begin
            errors++; $display("FAIL annul_restart: got lat=%0d res=%h want lat=32 res=000000020000000e", lat, res);
        end
    endtask

    task automatic test_reset_mid;
        int lat = 0;
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (14) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL rst_mid_clear: got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin lat = k; break; end
        end
        checks++;
        if (lat !== 32 || result_o !== 64'h00000002_0000000E) begin
            errors++; $display("FAIL rst_restart: got lat=%0d res=%h want lat=32 res=000000020000000e", lat, result_o);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL rst_end_clear: got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_drop();
        test_annul();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider for the integer datapath.
- It is the responder side of the EX-stage divide handshake. EX drives start_i, the operands and signed_div_i, and holds them until ready_o rises.
- Produces the 64-bit {remainder, quotient} result that EX writes to HI/LO for DIV/DIVU.
- One iteration per clock. Supports cancellation through annul_i.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at acceptance.
- opdata1_i  in  WIDTH  dividend; sampled at acceptance.
- opdata2_i  in  WIDTH  divisor; sampled at acceptance.
- start_i  in  1  request; the initiator holds it high until it sees ready_o=1, then drops it.
- annul_i  in  1  cancel the operation in progress.
- result_o  out  2*WIDTH  [63:32] remainder, [31:0] quotient; valid only while ready_o=1.
- ready_o  out  1  result valid (registered).

Behaviour:
- Reset: state=FREE, ready_o=0, result_o=0, counter=0, working registers=0. Reset takes effect asynchronously, including mid-operation, and the operation in progress is lost.
- States: FREE, DIVZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0, latch the operands and the sign mode.
  - If the divisor is 0, go to DIVZERO. Otherwise go to ON with cnt=0.
  - Otherwise stay in FREE.
  - Acceptance edge is T0.
- Operand preparation at acceptance:
  - Signed mode: each operand is replaced by its two's-complement magnitude (0x80000000 stays 0x80000000, treated as unsigned).
  - Record q_neg = sign1 XOR sign2 and r_neg = sign1.
  - Unsigned mode: q_neg = r_neg = 0.
- ON:
  - Working register is {rem[WIDTH], quo[WIDTH]}, initialised to {0, |dividend|}.
  - Each cycle: shift left by 1, then trial = rem_shifted − |divisor| using a WIDTH+1-bit subtract.
  - If trial ≥ 0: rem = trial and the new quotient LSB = 1. Otherwise the new quotient LSB = 0.
  - cnt increments each cycle.
  - After the 32nd iteration (cnt reaches 31 and increments), go to END.
  - On that same edge apply sign correction: quotient negated if q_neg, remainder negated if r_neg. Register result_o and set ready_o=1.
  - ready_o is first high in cycle T0+33.
- DIVZERO: next edge goes to END with result_o=0 and ready_o=1, so ready_o is first high at T0+2. Raising the divide-by-zero exception is not this block's job.
- END:
  - ready_o=1 and result_o held stable while start_i=1.
  - When start_i=0: go to FREE, ready_o=0, result_o=0.
  - annul_i is ignored in END.
- Annul: annul_i=1 in ON or DIVZERO forces FREE on the next edge with ready_o=0 and result_o=0. No result is produced.
- Operand or signed_div_i changes after acceptance have no effect.
- start_i low in ON or DIVZERO does not abort; only annul_i does. The result is still presented, and the block returns to FREE one cycle after END because start_i is already 0.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no flag).
- Results follow MIPS semantics: the quotient truncates toward zero and the remainder takes the dividend's sign.

Optional Feature:
- Macro: ITER_DIV_EARLY_OUT_EN.
- Defined: at acceptance, if |dividend| < |divisor| (divisor ≠ 0), skip ON and go straight to END on the next edge.
  - Quotient = 0 and remainder = the original signed/unsigned dividend.
  - ready_o high at T0+2.
  - The comparator is compiled in.
- Undefined: no comparator. Every nonzero-divisor operation takes the full 33-cycle path, and results are identical in value.

Test Plan:
- Unsigned 100/7, start held: ready_o=0 through T0+32, ready_o=1 at T0+33 with result_o=0x00000002_0000000E. Drop start_i: ready_o=0 and result_o=0 one cycle later.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) -> result_o = 0xFFFFFFFF_FFFFFFFD (r=−1, q=−3). Also signed 7/−2 -> 0x00000001_FFFFFFFD.
- Divisor 0 (any dividend) -> DIVZERO, ready_o=1 at T0+2 with result_o=0. With ITER_DIV_EARLY_OUT_EN, 3/10 unsigned -> ready_o at T0+2 with result_o=0x00000003_00000000.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000. Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- Annul: assert annul_i for 1 cycle at T0+10 in ON -> FREE next cycle and ready_o never rises. A new start then completes 100/7 correctly at T0'+33.
- Reset asynchronously at T0+15 between clock edges -> ready_o=0 and result_o=0 immediately, state FREE. After release, a held start_i is accepted on the next edge and completes normally.
